// File: rtl/cave_ioctl_pkg.sv
// cave_ioctl_pkg: shared ioctl upload/download types, widths and byte-swap helper.
package cave_ioctl_pkg;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_DATA, DRAIN} ioctl_state_t;

    localparam int DDR_DATA_W     = 64;
    localparam int IOCTL_DATA_W   = 16;
    localparam int WORDS_PER_LINE = 4;

    function automatic logic [IOCTL_DATA_W-1:0] byte_swap(input logic [IOCTL_DATA_W-1:0] w);
        return {w[7:0], w[15:8]};
    endfunction

endpackage

// File: rtl/ioctl_upload_reader.sv
// ioctl_upload_reader: answers HPS upload reads from a one-line 64-bit DDR cache,
// stalling with ioctl_wait while a missed line is fetched.
module ioctl_upload_reader
    import cave_ioctl_pkg::*;
#(
    parameter logic [7:0]  INDEX     = 8'd2,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter logic [26:0] SIZE      = 27'h10000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    ioctl_upload,
    input  logic                    ioctl_rd,
    input  logic [7:0]              ioctl_index,
    input  logic [26:0]             ioctl_addr,
    output logic [IOCTL_DATA_W-1:0] ioctl_din,
    output logic                    ioctl_wait,
    output logic                    ddr_rd,
    output logic [31:0]             ddr_addr,
    output logic [7:0]              ddr_burstLength,
    input  logic [DDR_DATA_W-1:0]   ddr_dout,
    input  logic                    ddr_waitReq,
    input  logic                    ddr_valid
);

    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + {6'b0, SIZE};

    if (END_ADDR > 33'h1_0000_0000) begin : g_range_err
        $error("ioctl_upload_reader: BASE_ADDR + SIZE exceeds the 32-bit address space");
    end

    ioctl_state_t state, state_n;
    logic [IOCTL_DATA_W-1:0] din_n;
    logic wait_n, rd_n, upload_q, line_valid, valid_n, abort, abort_n;
    logic [31:0] addr_n;
    logic [DDR_DATA_W-1:0] line, line_n;
    logic [23:0] line_tag, tag_n, req_tag, req_tag_n;
    logic [1:0] req_sel, req_sel_n;
    logic upload_edge, req, unused_addr_lsb;

    assign ddr_burstLength = 8'd1;
    assign upload_edge     = ioctl_upload ^ upload_q;
    assign req             = ioctl_rd & ioctl_upload & (ioctl_index == INDEX);
    assign unused_addr_lsb = ioctl_addr[0];

    always_comb begin
        state_n   = state;
        din_n     = ioctl_din;
        wait_n    = ioctl_wait;
        rd_n      = ddr_rd;
        addr_n    = ddr_addr;
        valid_n   = upload_edge ? 1'b0 : line_valid;
        line_n    = line;
        tag_n     = line_tag;
        req_tag_n = req_tag;
        req_sel_n = req_sel;
        abort_n   = abort;
        unique case (state)
            IDLE: begin
                abort_n = 1'b0;
                if (req) begin
                    if (ioctl_addr >= SIZE) begin
                        din_n = 16'hFFFF;
                    end else if (line_valid && !upload_edge && line_tag == ioctl_addr[26:3]) begin
                        din_n = byte_swap(line[{ioctl_addr[2:1], 4'b0} +: IOCTL_DATA_W]);
                    end else begin
                        req_tag_n = ioctl_addr[26:3];
                        req_sel_n = ioctl_addr[2:1];
                        wait_n    = 1'b1;
                        rd_n      = 1'b1;
                        addr_n    = BASE_ADDR + {5'b0, ioctl_addr[26:3], 3'b000};
                        state_n   = REQ;
                    end
                end
            end
            REQ: begin
                // a session that ends before acceptance still has its burst drained
                abort_n = abort | ~ioctl_upload;
                if (!ddr_waitReq) begin
                    rd_n    = 1'b0;
                    state_n = (abort || !ioctl_upload) ? DRAIN : WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (ddr_valid) begin
                    if (ioctl_upload) begin
                        line_n = ddr_dout;
                        tag_n  = req_tag;
                        din_n  = byte_swap(ddr_dout[{req_sel, 4'b0} +: IOCTL_DATA_W]);
                        if (!upload_edge) valid_n = 1'b1;
                    end
                    wait_n  = 1'b0;
                    state_n = IDLE;
                end else if (!ioctl_upload) begin
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (ddr_valid) begin
                    wait_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ioctl_din  <= '0;
            ioctl_wait <= 1'b0;
            ddr_rd     <= 1'b0;
            ddr_addr   <= '0;
            upload_q   <= 1'b0;
            line_valid <= 1'b0;
            line       <= '0;
            line_tag   <= '0;
            req_tag    <= '0;
            req_sel    <= '0;
            abort      <= 1'b0;
        end else begin
            state      <= state_n;
            ioctl_din  <= din_n;
            ioctl_wait <= wait_n;
            ddr_rd     <= rd_n;
            ddr_addr   <= addr_n;
            upload_q   <= ioctl_upload;
            line_valid <= valid_n;
            line       <= line_n;
            line_tag   <= tag_n;
            req_tag    <= req_tag_n;
            req_sel    <= req_sel_n;
            abort      <= abort_n;
        end
    end

endmodule

// File: tb/tb_ioctl_upload_reader.sv
// tb_ioctl_upload_reader: directed checks of hit/miss, backpressure, range, index,
// session invalidate, abort/drain and async reset.
module tb_ioctl_upload_reader;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic ioctl_upload = 1'b1;
    logic ioctl_rd = 1'b0;
    logic [7:0] ioctl_index = 8'd2;
    logic [26:0] ioctl_addr = '0;
    logic [15:0] ioctl_din;
    logic ioctl_wait, ddr_rd, ddr_waitReq = 1'b0, ddr_valid = 1'b0;
    logic [31:0] ddr_addr;
    logic [7:0] ddr_burstLength;
    logic [63:0] ddr_dout = '0;

    int checks = 0, passes = 0;
    int accepts = 0, rd_cycles = 0, unstable = 0;
    logic rd_prev = 1'b0, force_valid = 1'b0;
    logic [31:0] last_addr = '0;

    ioctl_upload_reader dut (
        .clock(clock), .reset(reset), .ioctl_upload(ioctl_upload), .ioctl_rd(ioctl_rd),
        .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din),
        .ioctl_wait(ioctl_wait), .ddr_rd(ddr_rd), .ddr_addr(ddr_addr),
        .ddr_burstLength(ddr_burstLength), .ddr_dout(ddr_dout),
        .ddr_waitReq(ddr_waitReq), .ddr_valid(ddr_valid)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] mem_word(input logic [31:0] a);
        return a == 32'h3000_0000 ? 64'h4444_3333_2222_1111 :
               a == 32'h3000_0008 ? 64'h8877_6655_4433_2211 : {a, ~a};
    endfunction

    // DDR model: data returns one cycle after acceptance
    always @(posedge clock) begin
        logic acc;
        logic [31:0] a;
        acc = ddr_rd && !ddr_waitReq;
        a = ddr_addr;
        if (acc) accepts++;
        if (ddr_rd) begin
            rd_cycles++;
            if (rd_prev && a != last_addr) unstable++;
            last_addr = a;
        end
        rd_prev = ddr_rd;
        if (ioctl_rd && ioctl_wait) $error("protocol violation: ioctl_rd while ioctl_wait");
        #1;
        ddr_valid = acc | force_valid;
        ddr_dout = acc ? mem_word(a) : force_valid ? 64'hDEAD_BEEF_DEAD_BEEF : ddr_dout;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic rd(input logic [26:0] a, input logic [7:0] idx = 8'd2);
        @(negedge clock);
        ioctl_addr = a;
        ioctl_index = idx;
        ioctl_rd = 1'b1;
        @(negedge clock);
        ioctl_rd = 1'b0;
        ioctl_index = 8'd2;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (ioctl_wait && n < 50) begin
            @(negedge clock);
            n++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        int n, r0, a0;
        @(negedge clock);
        check("rst_din", ioctl_din, 16'h0);
        check("rst_wait", ioctl_wait, 1'b0);
        check("rst_ddr_rd", ddr_rd, 1'b0);
        check("rst_ddr_addr", ddr_addr, 32'h0);
        check("burst_len", ddr_burstLength, 8'd1);
        reset = 1'b0;
        idle(2);

        r0 = rd_cycles; a0 = accepts;
        rd(27'h0);
        check("miss0_wait_hi", ioctl_wait, 1'b1);
        wait_done(n);
        check("miss0_wait_cycles", n, 2);
        check("miss0_din", ioctl_din, 16'h1111);
        check("miss0_rd_cycles", rd_cycles - r0, 1);
        check("miss0_accepts", accepts - a0, 1);
        check("miss0_addr", last_addr, 32'h3000_0000);

        r0 = rd_cycles;
        rd(27'h6);
        check("hit6_wait", ioctl_wait, 1'b0);
        check("hit6_din", ioctl_din, 16'h4444);
        rd(27'h4);
        check("hit4_din", ioctl_din, 16'h3333);
        check("hit_no_ddr", rd_cycles - r0, 0);

        r0 = rd_cycles; a0 = accepts; unstable = 0;
        ddr_waitReq = 1'b1;
        rd(27'ha);
        idle(5);
        ddr_waitReq = 1'b0;
        wait_done(n);
        check("bp_wait_done", ioctl_wait, 1'b0);
        check("bp_rd_cycles", rd_cycles - r0, 6);
        check("bp_accepts", accepts - a0, 1);
        check("bp_stable", unstable, 0);
        check("bp_addr", last_addr, 32'h3000_0008);
        check("bp_din", ioctl_din, 16'h3344);
        r0 = rd_cycles;
        rd(27'hc);
        check("hit12_din", ioctl_din, 16'h5566);

        rd(27'h10000);
        check("oor_din", ioctl_din, 16'hFFFF);
        check("oor_wait", ioctl_wait, 1'b0);
        idle(3);
        check("oor_no_ddr", rd_cycles - r0, 0);

        rd(27'h0, 8'd0);
        check("idx_wait", ioctl_wait, 1'b0);
        idle(3);
        check("idx_din", ioctl_din, 16'hFFFF);
        check("idx_no_ddr", rd_cycles - r0, 0);

        rd(27'h0);
        wait_done(n);
        check("sess_fill_din", ioctl_din, 16'h1111);
        r0 = rd_cycles;
        rd(27'h0);
        check("sess_hit_no_ddr", rd_cycles - r0, 0);
        ioctl_upload = 1'b0;
        idle(2);
        ioctl_upload = 1'b1;
        idle(2);
        rd(27'h0);
        wait_done(n);
        check("sess_remiss", rd_cycles - r0, 1);
        check("sess_din", ioctl_din, 16'h1111);

        a0 = accepts;
        rd(27'h8);
        ioctl_upload = 1'b0;
        wait_done(n);
        check("abort_wd_wait", ioctl_wait, 1'b0);
        check("abort_wd_din", ioctl_din, 16'h1111);
        check("abort_wd_accepts", accepts - a0, 1);
        ioctl_upload = 1'b1;
        idle(2);
        a0 = accepts;
        ddr_waitReq = 1'b1;
        rd(27'h10);
        ioctl_upload = 1'b0;
        idle(1);
        ddr_waitReq = 1'b0;
        wait_done(n);
        check("abort_req_wait", ioctl_wait, 1'b0);
        check("abort_req_din", ioctl_din, 16'h1111);
        check("abort_req_accepts", accepts - a0, 1);
        idle(2);
        ioctl_upload = 1'b1;
        idle(2);
        r0 = rd_cycles;
        rd(27'h0);
        wait_done(n);
        check("new_sess_miss", rd_cycles - r0, 1);
        check("new_sess_din", ioctl_din, 16'h1111);

        force_valid = 1'b1;
        idle(1);
        force_valid = 1'b0;
        idle(2);
        r0 = rd_cycles;
        rd(27'h6);
        check("spur_wait", ioctl_wait, 1'b0);
        check("spur_din", ioctl_din, 16'h4444);
        check("spur_no_ddr", rd_cycles - r0, 0);

        ddr_waitReq = 1'b1;
        rd(27'h18);
        check("rstreq_rd_hi", ddr_rd, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("rstreq_rd", ddr_rd, 1'b0);
        check("rstreq_wait", ioctl_wait, 1'b0);
        check("rstreq_addr", ddr_addr, 32'h0);
        check("rstreq_din", ioctl_din, 16'h0);
        @(negedge clock);
        reset = 1'b0;
        ddr_waitReq = 1'b0;
        idle(2);
        r0 = rd_cycles;
        rd(27'h0);
        wait_done(n);
        check("post_rst_miss", rd_cycles - r0, 1);
        check("post_rst_din", ioctl_din, 16'h1111);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
